// File: rtl/fib_seq_gen.sv
// Additive-sequence generator: streams num_terms terms of a(n)=a(n-1)+a(n-2) from two seeds.
// Ports: clk, rst_n, start/seed_a/seed_b/num_terms, halt -> term/term_valid/term_idx, busy, done, overflow.
// Optional: define FIB_SAT_EN to emit all-ones on the first wrapped term and end the run there.
module fib_seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             halt,
  output logic [WIDTH-1:0] term,
  output logic             term_valid,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
`ifdef FIB_SAT_EN
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};
`endif

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ca;
  logic             cb;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] idx;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // ca/cb mark a and b as already wrapped; a wrap taints every later term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a          <= '0;
      b          <= '0;
      ca         <= 1'b0;
      cb         <= 1'b0;
      remaining  <= '0;
      idx        <= '0;
      term       <= '0;
      term_valid <= 1'b0;
      term_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          term_valid <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            a         <= seed_a;
            b         <= seed_b;
            ca        <= 1'b0;
            cb        <= 1'b0;
            remaining <= num_terms;
            idx       <= '0;
            overflow  <= 1'b0;
            // A zero-length run passes through RUN idle so done lands one cycle later.
            busy      <= (num_terms != '0);
            state     <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (remaining == '0) begin
            term_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else if (halt) begin
            term_valid <= 1'b0;
          end else begin
            term_valid <= 1'b1;
            term_idx   <= idx;
            idx        <= idx + ONE;
            remaining  <= remaining - ONE;
            a          <= b;
            ca         <= cb;
            b          <= sum[WIDTH-1:0];
            cb         <= sum[WIDTH] | ca | cb;
`ifdef FIB_SAT_EN
            if (ca) begin
              term      <= ALL1;
              overflow  <= 1'b1;
              remaining <= '0;
            end else begin
              term <= a;
            end
`else
            term     <= a;
            overflow <= overflow | ca;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: vector table, queue scoreboard, hand-written corner sequences.
// Expected terms come from an unbounded-integer Fibonacci model.
module tb_fib_seq_gen;

  localparam int W = 8;
  localparam int C = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] seed_a;
  logic [W-1:0] seed_b;
  logic [C-1:0] num_terms;
  logic         halt;
  logic [W-1:0] term;
  logic         term_valid;
  logic [C-1:0] term_idx;
  logic         busy;
  logic         done;
  logic         overflow;

  fib_seq_gen #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed_a(seed_a),
    .seed_b(seed_b),
    .num_terms(num_terms),
    .halt(halt),
    .term(term),
    .term_valid(term_valid),
    .term_idx(term_idx),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sa;
    int sb;
    int n;
    int halt_at;
    int halt_len;
    int inj_at;
  } vec_t;

  typedef struct {
    logic [W-1:0] t;
    logic [C-1:0] i;
    logic         o;
  } exp_t;

  exp_t q[$];
  vec_t vecs[9];
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Model: true (unbounded) values; a term has wrapped iff it is >= 2^W.
  task automatic model(input vec_t v);
    longint x;
    longint y;
    longint nx;
    bit     ovf;
    exp_t   e;
    x = v.sa;
    y = v.sb;
    ovf = 0;
    exp_cnt = 0;
    for (int i = 0; i < v.n; i++) begin
      ovf = ovf | (x >= 256);
`ifdef FIB_SAT_EN
      if (x >= 256) begin
        e.t = 8'hFF;
        e.i = C'(i);
        e.o = 1'b1;
        q.push_back(e);
        exp_cnt++;
        break;
      end
`endif
      e.t = W'(x % 256);
      e.i = C'(i);
      e.o = ovf;
      q.push_back(e);
      exp_cnt++;
      nx = x + y;
      x = y;
      y = nx;
    end
  endtask

  // Called #1 after an edge; start is sampled at the next edge.
  task automatic launch(input vec_t v);
    model(v);
    seed_a = W'(v.sa);
    seed_b = W'(v.sb);
    num_terms = C'(v.n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("acc_busy", busy, (v.n != 0));
    chk("acc_done", done, 0);
    chk("acc_tv", term_valid, 0);
  endtask

  task automatic watch(input vec_t v);
    int   hleft;
    int   halts;
    bit   seen;
    exp_t e;
    logic [W-1:0] last;
    hleft = 0;
    seen = 0;
    last = '0;
    halts = (v.halt_at >= 0) ? v.halt_len : 0;
    for (int c = 1; c <= exp_cnt + halts + 10; c++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (halt) begin
        chk("halt_tv", term_valid, 0);
        chk("halt_hold", term, last);
        hleft--;
        if (hleft == 0) halt = 1'b0;
      end else if (term_valid) begin
        if (q.size() == 0) begin
          fail("extra_term");
        end else begin
          e = q.pop_front();
          chk("term", term, e.t);
          chk("idx", term_idx, e.i);
          chk("ovf", overflow, e.o);
          chk("run_busy", busy, 1);
        end
        last = term;
        if (v.halt_at >= 0 && int'(term_idx) == v.halt_at) begin
          halt = 1'b1;
          hleft = v.halt_len;
        end
        if (v.inj_at >= 0 && int'(term_idx) == v.inj_at) begin
          start = 1'b1;
          seed_a = 8'd77;
          seed_b = 8'd99;
          num_terms = 8'd2;
        end
      end
      if (done) begin
        chk("done_cyc", c, exp_cnt + 1 + halts);
        chk("q_empty", q.size(), 0);
        chk("done_busy", busy, 0);
        chk("done_tv", term_valid, 0);
        seen = 1;
        break;
      end
    end
    if (!seen) fail("done_timeout");
    q.delete();
    halt = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_term"}, term, 0);
    chk({nm, "_tv"}, term_valid, 0);
    chk({nm, "_idx"}, term_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_ovf"}, overflow, 0);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    bit   hit;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    seed_a = '0;
    seed_b = '0;
    num_terms = '0;

    vecs[0] = '{1, 1, 12, -1, 0, -1};
    vecs[1] = '{1, 1, 14, -1, 0, -1};
    vecs[2] = '{1, 1, 3, -1, 0, -1};
    vecs[3] = '{2, 1, 6, 2, 3, -1};
    vecs[4] = '{200, 100, 5, -1, 0, -1};
    vecs[5] = '{255, 255, 4, -1, 0, -1};
    vecs[6] = '{1, 2, 10, -1, 0, 3};
    vecs[7] = '{0, 0, 255, -1, 0, -1};
    vecs[8] = '{0, 0, 1, -1, 0, -1};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
      launch(vecs[i]);
      watch(vecs[i]);
    end

    // Zero-length run, then a start accepted during its DONE cycle.
    v = '{9, 9, 0, -1, 0, -1};
    launch(v);
    watch(v);
    v = '{3, 5, 3, -1, 0, -1};
    launch(v);
    watch(v);

    // Asynchronous reset during idx 4 of a 10-term wrapping run.
    repeat (2) @(posedge clk);
    #1;
    v = '{200, 100, 10, -1, 0, -1};
    launch(v);
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (term_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("rr_term", term, e.t);
        chk("rr_idx", term_idx, e.i);
      end
      if (term_valid && term_idx == 8'd4) begin
        hit = 1;
        break;
      end
    end
    if (!hit) fail("rr_timeout");
    chk("rr_ovf_pre", overflow, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_tv", term_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
    end
    launch(vecs[0]);
    watch(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
